// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtract sequencer.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// One-bit full subtractor: o_diff = a - b - b_in, o_b_out set when a < b + b_in.
module full_sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_b_in,
  output logic o_diff,
  output logic o_b_out
);

  assign o_diff  = i_a ^ i_b ^ i_b_in;
  assign o_b_out = (~i_a & (i_b | i_b_in)) | (i_b & i_b_in);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtract sequencer: diff = a - b - b_in over WIDTH cycles, LSB first.
// Optional signed-overflow output o_ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_b_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_sd_next;

  full_sub_cell u_cell (
    .i_a    (r_sa[0]),
    .i_b    (r_sb[0]),
    .i_b_in (r_borrow),
    .o_diff (w_d),
    .o_b_out(w_bo)
  );

  // Shift-based insert keeps the expression legal for WIDTH == 1.
  assign w_sd_next = (r_sd >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sd     <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_diff   <= '0;
      o_b_out  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      o_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_sa     <= i_a;
            r_sb     <= i_b;
            r_borrow <= i_b_in;
            r_cnt    <= '0;
            o_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_sa     <= r_sa >> 1;
          r_sb     <= r_sb >> 1;
          r_sd     <= w_sd_next;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            o_diff  <= w_sd_next;
            o_b_out <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
            o_ovf   <= r_borrow ^ w_bo;
`endif
            o_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // The DONE->IDLE edge doubles as the accept slot so throughput is WIDTH+1.
          o_done <= 1'b0;
          if (i_start) begin
            r_sa     <= i_a;
            r_sb     <= i_b;
            r_borrow <= i_b_in;
            r_cnt    <= '0;
            r_state  <= RUN;
          end else begin
            o_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl (WIDTH=8 instance plus a WIDTH=1 instance).
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done, bout;
  logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  logic       start1, a1, b1, bin1;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_a    (a),
    .i_b    (b),
    .i_b_in (bin),
    .o_busy (busy),
    .o_done (done),
    .o_diff (diff),
    .o_b_out(bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .o_ovf  (ovf)
`endif
  );

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start1),
    .i_a    (a1),
    .i_b    (b1),
    .i_b_in (bin1),
    .o_busy (busy1),
    .o_done (done1),
    .o_diff (diff1),
    .o_b_out(bout1)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .o_ovf  ()
`endif
  );

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++; if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b exp=0", bout); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL reset_w1 busy=%b done=%b exp=0/0", busy1, done1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input logic [7:0] ed, input logic eb, input logic eo, input string name);
    logic [7:0] prev;
    int n_busy, t_done, n_done;
    prev = diff;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb; bin = ~tbin;
    n_busy = (busy === 1'b1) ? 1 : 0;
    t_done = -1;
    n_done = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n_busy++;
      if (done === 1'b1) begin
        n_done++;
        if (t_done < 0) t_done = i;
      end
      if (i == 4) begin
        checks++;
        if (diff !== prev) begin failures++; $display("FAIL %s_partial got=%h exp=%h", name, diff, prev); end
      end
    end
    checks++; if (t_done != 8) begin failures++; $display("FAIL %s_latency got=%0d exp=8", name, t_done); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", name, n_done); end
    checks++; if (n_busy != 9) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=9", name, n_busy); end
    checks++; if (diff !== ed) begin failures++; $display("FAIL %s_diff got=%h exp=%h", name, diff, ed); end
    checks++; if (bout !== eb) begin failures++; $display("FAIL %s_bout got=%b exp=%b", name, bout, eb); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ovf !== eo) begin failures++; $display("FAIL %s_ovf got=%b exp=%b", name, ovf, eo); end
`else
    if (eo === 1'bx) $display("note: %s ovf expectation undefined", name);
`endif
    a = 8'h00; b = 8'h00; bin = 1'b0;
  endtask

  task automatic test_start_held;
    int t1, t2, n_done;
    logic [7:0] d1, d2;
    logic bo2;
    t1 = -1; t2 = -1; n_done = 0; d1 = 8'h00; d2 = 8'h00; bo2 = 1'b1;
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h40; b = 8'h01;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 9) start = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        if (t1 < 0) begin t1 = cyc; d1 = diff; end
        else if (t2 < 0) begin t2 = cyc; d2 = diff; bo2 = bout; end
      end
    end
    checks++; if (n_done != 2) begin failures++; $display("FAIL held_done_count got=%0d exp=2", n_done); end
    checks++; if (t1 != 8) begin failures++; $display("FAIL held_first_done got=%0d exp=8", t1); end
    checks++; if (t2 != 17) begin failures++; $display("FAIL held_second_done got=%0d exp=17", t2); end
    checks++; if (d1 !== 8'h02) begin failures++; $display("FAIL held_diff1 got=%h exp=02", d1); end
    checks++; if (d2 !== 8'h3F) begin failures++; $display("FAIL held_diff2 got=%h exp=3f", d2); end
    checks++; if (bo2 !== 1'b0) begin failures++; $display("FAIL held_bout2 got=%b exp=0", bo2); end
    a = 8'h00; b = 8'h00;
  endtask

  task automatic test_rst_abort;
    int n_done;
    n_done = 0;
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (diff !== 8'h00) begin failures++; $display("FAIL abort_diff got=%h exp=00", diff); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_width1;
    logic [7:0] exp_d, exp_bo;
    logic [2:0] idx;
    exp_d  = 8'b1001_0110;
    exp_bo = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      @(negedge clk);
      a1 = idx[2]; b1 = idx[1]; bin1 = idx[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || diff1[0] !== exp_d[i] || bout1 !== exp_bo[i])
        begin failures++; $display("FAIL w1_combo%0d done=%b diff=%b bout=%b exp=1/%b/%b", i, done1, diff1[0], bout1, exp_d[i], exp_bo[i]); end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0)
        begin failures++; $display("FAIL w1_idle%0d done=%b busy=%b exp=0/0", i, done1, busy1); end
    end
  endtask

  initial begin
    test_reset();
    test_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "sub_basic");
    test_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "sub_wrap");
    test_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_borrow_in");
    test_start_held();
    test_rst_abort();
    test_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "after_rst");
    test_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "ovf_neg");
    test_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "ovf_pos");
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
